// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift requesters and the shared shifter arbiter.
// The master side is the requesters; the slave side is the arbiter.
interface shift_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic [31:0] req_data0;
    logic [4:0]  req_amt0;
    logic [31:0] req_data1;
    logic [4:0]  req_amt1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data0;
    logic [31:0] resp_data1;
    logic        owner;
    logic        locked;

    modport master (
        output req_valid, req_lock, req_data0, req_amt0, req_data1, req_amt1, resp_ready,
        input  req_ready, resp_valid, resp_data0, resp_data1, owner, locked
    );

    modport slave (
        input  req_valid, req_lock, req_data0, req_amt0, req_data1, req_amt1, resp_ready,
        output req_ready, resp_valid, resp_data0, resp_data1, owner, locked
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter with bounded lock sharing one 32-bit left shifter; result registered, 1-cycle latency.
// Backpressure: a requester is only granted when its response slot is empty or being drained this cycle.
module shift_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    shift_arbiter_if.slave  bus
);

    typedef enum logic {ARB, LOCKED} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [31:0] resp_data0_q, resp_data1_q;

    logic [1:0]  slot_free, elig, grant;
    logic        gidx, accept;
    logic [31:0] sh_data, sh_res;
    logic [4:0]  sh_amt;

    always_comb begin
        slot_free = ~resp_valid_q | bus.resp_ready;
        elig      = bus.req_valid & slot_free;
    end

    // Grant selection: the lock owner is the only candidate while locked.
    always_comb begin
        gidx   = 1'b0;
        accept = 1'b0;
        if (state_q == LOCKED) begin
            gidx   = owner_q;
            accept = elig[owner_q];
        end else begin
            unique case (elig)
                2'b01:   begin gidx = 1'b0;  accept = 1'b1; end
                2'b10:   begin gidx = 1'b1;  accept = 1'b1; end
                2'b11:   begin gidx = ptr_q; accept = 1'b1; end
                default: begin gidx = 1'b0;  accept = 1'b0; end
            endcase
        end
        if (!reset_n) accept = 1'b0;
        grant = {accept & gidx, accept & ~gidx};
    end

    always_comb begin
        sh_data = gidx ? bus.req_data1 : bus.req_data0;
        sh_amt  = gidx ? bus.req_amt1  : bus.req_amt0;
        sh_res  = sh_data << sh_amt;
    end

    // The count includes the grant that takes the lock, so a lock spans at most MAX_LOCK grants.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (accept) ptr_d = ~gidx;
        unique case (state_q)
            ARB: begin
                if (accept && bus.req_lock[gidx]) begin
                    owner_d = gidx;
                    if (MAX_CNT != 4'd1) begin
                        state_d = LOCKED;
                        cnt_d   = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (bus.req_lock[owner_q] && (cnt_q < MAX_CNT - 4'd1)) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        state_d = ARB;
                        cnt_d   = 4'd0;
                    end
                end else if (!bus.req_lock[owner_q]) begin
                    state_d = ARB;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = ARB;
        endcase
        resp_valid_d = (resp_valid_q & ~bus.resp_ready) | grant;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            ptr_q        <= 1'b0;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_data0_q <= 32'd0;
            resp_data1_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            resp_valid_q <= resp_valid_d;
            if (grant[0]) resp_data0_q <= sh_res;
            if (grant[1]) resp_data1_q <= sh_res;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data0 = resp_data0_q;
    assign bus.resp_data1 = resp_data1_q;
    assign bus.owner      = owner_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule
